// File: rtl/audio_feed_tick_sched.sv
`default_nettype none
// ============================================================================
// Module      : audio_feed_tick_sched
// Description : Sequencer and sole master of the audio-feed interval timer's
//               Avalon-MM slave port. It programs the period and control
//               registers and starts the timer in continuous interrupt mode.
//               It services each timeout IRQ by clearing the status register.
//               Every serviced timeout becomes a sample tick on a valid/ready
//               handshake, and is counted by a 16-bit tick counter. A sticky
//               overrun flag records a tick that arrived while one was still
//               pending.
//
// Ports       : clk, reset_n          clock, asynchronous active-low reset
//               enable                level, timer should run
//               period_in[31:0]       requested reload value (0 = default)
//               period_update         pulse, reprogram period while running
//               tick_valid/tick_ready sample-tick handshake
//               tick_count[15:0]      timeouts serviced, modulo 2^16
//               overrun/overrun_clr   sticky overrun flag and its clear
//               running               high in RUN/ACK
//               tmr_*                 write-only timer register port
//
// Revision    : 1.0 - initial release
// ============================================================================
module audio_feed_tick_sched #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd1133
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] period_in,
    input  logic        period_update,
    output logic        tick_valid,
    input  logic        tick_ready,
    output logic [15:0] tick_count,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic        running,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic        tmr_irq
);

    localparam logic [2:0]  c_ADDR_STATUS = 3'd0;
    localparam logic [2:0]  c_ADDR_CTRL   = 3'd1;
    localparam logic [2:0]  c_ADDR_PERL   = 3'd2;
    localparam logic [2:0]  c_ADDR_PERH   = 3'd3;
    localparam logic [15:0] c_START_WORD  = 16'h0007;  // ITO | CONT | START
    localparam logic [15:0] c_STOP_WORD   = 16'h0008;  // STOP

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_PL  = 3'd1,
        S_WR_PH  = 3'd2,
        S_WR_CTL = 3'd3,
        S_RUN    = 3'd4,
        S_ACK    = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_eff_period;
    logic [31:0] w_next_eff;
    logic [31:0] w_sel_period;
    logic        r_pending;
    logic        w_next_pending;

    logic        w_bus_cs;
    logic [2:0]  w_bus_addr;
    logic [15:0] w_bus_data;

    logic        r_cs;
    logic [2:0]  r_addr;
    logic [15:0] r_data;
    logic        r_running;
    logic        r_tick_valid;
    logic [15:0] r_tick_count;
    logic        r_overrun;
    logic        w_ovr_set;

    assign w_sel_period = (period_in == 32'd0) ? DEFAULT_PERIOD : period_in;

    // Next-state logic. The bus outputs are derived from the next state so
    // that the registered write strobe lines up with the write state itself.
    always_comb begin
        w_next_state   = r_state;
        w_next_eff     = r_eff_period;
        w_next_pending = r_pending;
        case (r_state)
            S_IDLE: begin
                w_next_pending = 1'b0;
                if (enable) begin
                    w_next_eff   = w_sel_period;
                    w_next_state = S_WR_PL;
                end
            end
            S_WR_PL: begin
                if (period_update) w_next_pending = 1'b1;
                w_next_state = S_WR_PH;
            end
            S_WR_PH: begin
                if (period_update) w_next_pending = 1'b1;
                w_next_state = S_WR_CTL;
            end
            S_WR_CTL: begin
                if (period_update) w_next_pending = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                if (!enable) begin
                    w_next_pending = 1'b0;
                    w_next_state   = S_STOP;
                end else if (period_update || r_pending) begin
                    // Rewriting the period halts the timer; the write
                    // sequence ends with a fresh start command.
                    w_next_pending = 1'b0;
                    w_next_eff     = w_sel_period;
                    w_next_state   = S_WR_PL;
                end else if (tmr_irq) begin
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                if (period_update) w_next_pending = 1'b1;
                w_next_state = S_RUN;
            end
            S_STOP: begin
                w_next_pending = 1'b0;
                w_next_state   = S_IDLE;
            end
            default: begin
                w_next_pending = 1'b0;
                w_next_state   = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_bus_cs   = 1'b0;
        w_bus_addr = 3'd0;
        w_bus_data = 16'h0000;
        case (w_next_state)
            S_WR_PL: begin
                w_bus_cs   = 1'b1;
                w_bus_addr = c_ADDR_PERL;
                w_bus_data = w_next_eff[15:0];
            end
            S_WR_PH: begin
                w_bus_cs   = 1'b1;
                w_bus_addr = c_ADDR_PERH;
                w_bus_data = w_next_eff[31:16];
            end
            S_WR_CTL: begin
                w_bus_cs   = 1'b1;
                w_bus_addr = c_ADDR_CTRL;
                w_bus_data = c_START_WORD;
            end
            S_ACK: begin
                w_bus_cs   = 1'b1;
                w_bus_addr = c_ADDR_STATUS;
                w_bus_data = 16'h0000;
            end
            S_STOP: begin
                w_bus_cs   = 1'b1;
                w_bus_addr = c_ADDR_CTRL;
                w_bus_data = c_STOP_WORD;
            end
            default: begin
                w_bus_cs   = 1'b0;
                w_bus_addr = 3'd0;
                w_bus_data = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_eff_period <= DEFAULT_PERIOD;
            r_pending    <= 1'b0;
            r_cs         <= 1'b0;
            r_addr       <= 3'd0;
            r_data       <= 16'h0000;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_eff_period <= w_next_eff;
            r_pending    <= w_next_pending;
            r_cs         <= w_bus_cs;
            r_addr       <= w_bus_addr;
            r_data       <= w_bus_data;
            r_running    <= (w_next_state == S_RUN) || (w_next_state == S_ACK);
        end
    end

    // A new tick while the previous one is still unaccepted collapses into
    // the single pending tick and flags an overrun.
    assign w_ovr_set = (r_state == S_ACK) && r_tick_valid && !tick_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_valid <= 1'b0;
            r_tick_count <= 16'h0000;
            r_overrun    <= 1'b0;
        end else begin
            if (r_state == S_ACK) begin
                r_tick_valid <= 1'b1;
                r_tick_count <= r_tick_count + 16'd1;
            end else if (r_tick_valid && tick_ready) begin
                r_tick_valid <= 1'b0;
            end
            if (overrun_clr) begin
                r_overrun <= 1'b0;
            end else if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign tmr_chipselect = r_cs;
    assign tmr_write_n    = ~r_cs;
    assign tmr_address    = r_addr;
    assign tmr_writedata  = r_data;
    assign running        = r_running;
    assign tick_valid     = r_tick_valid;
    assign tick_count     = r_tick_count;
    assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_feed_tick_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_feed_tick_sched
// Description : Self-checking bench for audio_feed_tick_sched with a
//               behavioural interval-timer model on the Avalon port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_feed_tick_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] period_in = 32'd0;
    logic        period_update = 1'b0;
    logic        tick_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        tmr_irq;
    logic        tick_valid;
    logic [15:0] tick_count;
    logic        overrun;
    logic        running;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    audio_feed_tick_sched dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .period_in      (period_in),
        .period_update  (period_update),
        .tick_valid     (tick_valid),
        .tick_ready     (tick_ready),
        .tick_count     (tick_count),
        .overrun        (overrun),
        .overrun_clr    (overrun_clr),
        .running        (running),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Interval timer model: timeout every period+1 cycles once started,
    // period writes halt it, status write clears the timeout.
    logic [31:0] t_period;
    logic [31:0] t_cnt;
    logic        t_run;
    wire         t_wr = tmr_chipselect && !tmr_write_n;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_period <= 32'd0;
            t_cnt    <= 32'd0;
            t_run    <= 1'b0;
            tmr_irq  <= 1'b0;
        end else begin
            if (t_wr && tmr_address == 3'd0) tmr_irq <= 1'b0;
            if (t_wr && tmr_address == 3'd2) begin
                t_period[15:0] <= tmr_writedata;
                t_run <= 1'b0;
            end else if (t_wr && tmr_address == 3'd3) begin
                t_period[31:16] <= tmr_writedata;
                t_run <= 1'b0;
            end else if (t_wr && tmr_address == 3'd1) begin
                if (tmr_writedata[3]) t_run <= 1'b0;
                else if (tmr_writedata[2]) begin
                    t_run <= 1'b1;
                    t_cnt <= t_period;
                end
            end else if (t_run) begin
                if (t_cnt == 32'd0) begin
                    tmr_irq <= 1'b1;
                    t_cnt   <= t_period;
                end else begin
                    t_cnt <= t_cnt - 32'd1;
                end
            end
        end
    end

    typedef struct {
        logic        cs;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        run;
    } bus_vec_t;

    bus_vec_t tbl [0:15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_tbl(input int first, input int last, input string name);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            period_update = 1'b0;
            overrun_clr   = 1'b0;
            chk($sformatf("%s[%0d].cs", name, i), {31'd0, tmr_chipselect}, {31'd0, tbl[i].cs});
            chk($sformatf("%s[%0d].wn", name, i), {31'd0, tmr_write_n}, {31'd0, ~tbl[i].cs});
            chk($sformatf("%s[%0d].addr", name, i), {29'd0, tmr_address}, {29'd0, tbl[i].addr});
            chk($sformatf("%s[%0d].data", name, i), {16'd0, tmr_writedata}, {16'd0, tbl[i].data});
            chk($sformatf("%s[%0d].running", name, i), {31'd0, running}, {31'd0, tbl[i].run});
        end
    endtask

    task automatic wait_ack(input int bound, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: no status write within %0d cycles", bound);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".cs"}, {31'd0, tmr_chipselect}, 32'd0);
        chk({tag, ".wn"}, {31'd0, tmr_write_n}, 32'd1);
        chk({tag, ".addr"}, {29'd0, tmr_address}, 32'd0);
        chk({tag, ".data"}, {16'd0, tmr_writedata}, 32'd0);
        chk({tag, ".tick_valid"}, {31'd0, tick_valid}, 32'd0);
        chk({tag, ".tick_count"}, {16'd0, tick_count}, 32'd0);
        chk({tag, ".overrun"}, {31'd0, overrun}, 32'd0);
        chk({tag, ".running"}, {31'd0, running}, 32'd0);
    endtask

    // Reference model state for the randomized phase.
    logic        m_ack, m_tv, m_ov, nxt_ack, r_in, clr_in;
    logic [15:0] m_cnt;
    logic [15:0] exp_cnt;

    initial begin
        int at;
        int prev;
        int c0;

        repeat (3) @(negedge clk);
        check_reset("rst");
        reset_n = 1'b1;
        exp_cnt = 16'd0;
        @(negedge clk);

        // Start with period_in = 0 -> default period 1133 = 0x046D.
        tbl[0] = '{1'b1, 3'd2, 16'h046D, 1'b0};
        tbl[1] = '{1'b1, 3'd3, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 3'd1, 16'h0007, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 16'h0000, 1'b1};
        enable    = 1'b1;
        period_in = 32'd0;
        apply_tbl(0, 3, "start");

        // Reprogram to 99 -> timeouts every 100 cycles.
        @(negedge clk);
        period_in     = 32'd99;
        period_update = 1'b1;
        tbl[0] = '{1'b1, 3'd2, 16'd99, 1'b0};
        tbl[1] = '{1'b1, 3'd3, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 3'd1, 16'h0007, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 16'h0000, 1'b1};
        apply_tbl(0, 3, "upd99");

        tick_ready = 1'b1;
        prev = -1;
        for (int k = 0; k < 20; k++) begin
            wait_ack(250, at);
            if (at < 0) break;
            chk("ack_data", {16'd0, tmr_writedata}, 32'd0);
            if (prev >= 0) chk("tick_interval", at - prev, 100);
            prev = at;
            @(negedge clk);
            exp_cnt = exp_cnt + 16'd1;
            chk("tick_valid_set", {31'd0, tick_valid}, 32'd1);
            chk("tick_count", {16'd0, tick_count}, {16'd0, exp_cnt});
            chk("no_overrun", {31'd0, overrun}, 32'd0);
            @(negedge clk);
            chk("tick_valid_taken", {31'd0, tick_valid}, 32'd0);
        end

        // Two unaccepted ticks -> overrun.
        tick_ready = 1'b0;
        wait_ack(250, at);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        chk("ovr1.tick_valid", {31'd0, tick_valid}, 32'd1);
        chk("ovr1.overrun", {31'd0, overrun}, 32'd0);
        wait_ack(250, at);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        chk("ovr2.tick_valid", {31'd0, tick_valid}, 32'd1);
        chk("ovr2.overrun", {31'd0, overrun}, 32'd1);
        chk("ovr2.tick_count", {16'd0, tick_count}, {16'd0, exp_cnt});
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("ovr_clr.overrun", {31'd0, overrun}, 32'd0);
        chk("ovr_clr.tick_valid", {31'd0, tick_valid}, 32'd1);
        tick_ready = 1'b1;
        @(negedge clk);
        tick_ready = 1'b0;
        chk("ovr_take.tick_valid", {31'd0, tick_valid}, 32'd0);

        // Short period for the randomized handshake phase.
        period_in     = 32'd7;
        period_update = 1'b1;
        tbl[0] = '{1'b1, 3'd2, 16'd7, 1'b0};
        apply_tbl(0, 3, "upd7");

        m_ack = 1'b0;
        m_tv  = 1'b0;
        m_ov  = 1'b0;
        m_cnt = exp_cnt;
        for (int it = 0; it < 1500; it++) begin
            chk("rnd.ack", {31'd0, (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0
                                    && tmr_writedata == 16'h0000)}, {31'd0, m_ack});
            chk("rnd.tick_valid", {31'd0, tick_valid}, {31'd0, m_tv});
            chk("rnd.tick_count", {16'd0, tick_count}, {16'd0, m_cnt});
            chk("rnd.overrun", {31'd0, overrun}, {31'd0, m_ov});
            r_in   = 1'($urandom_range(0, 1));
            clr_in = ($urandom_range(0, 7) == 0);
            tick_ready  = r_in;
            overrun_clr = clr_in;
            nxt_ack = tmr_irq && !m_ack;
            if (m_ack) begin
                m_cnt = m_cnt + 16'd1;
                if (m_tv && !r_in) m_ov = 1'b1;
                m_tv = 1'b1;
            end else if (m_tv && r_in) begin
                m_tv = 1'b0;
            end
            if (clr_in) m_ov = 1'b0;
            m_ack = nxt_ack;
            @(negedge clk);
        end
        tick_ready  = 1'b1;
        overrun_clr = 1'b0;

        // Reprogram to 0x00010000 right after an ACK.
        wait_ack(50, at);
        @(negedge clk);
        period_in     = 32'h0001_0000;
        period_update = 1'b1;
        tbl[0] = '{1'b1, 3'd2, 16'h0000, 1'b0};
        tbl[1] = '{1'b1, 3'd3, 16'h0001, 1'b0};
        tbl[2] = '{1'b1, 3'd1, 16'h0007, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 16'h0000, 1'b1};
        apply_tbl(0, 3, "upd64k");
        c0 = cyc;
        wait_ack(70000, at);
        if (at >= 0) chk("p65537_first_ack", at - c0, 65538);

        // enable dropped during WR_PH: sequence completes, then stop.
        @(negedge clk);
        period_in     = 32'd7;
        period_update = 1'b1;
        tbl[0] = '{1'b1, 3'd2, 16'd7, 1'b0};
        apply_tbl(0, 0, "endrop");
        enable = 1'b0;
        tbl[1] = '{1'b1, 3'd3, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 3'd1, 16'h0007, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 16'h0000, 1'b1};
        tbl[4] = '{1'b1, 3'd1, 16'h0008, 1'b0};
        tbl[5] = '{1'b0, 3'd0, 16'h0000, 1'b0};
        apply_tbl(1, 5, "endrop");

        // period_update during WR_PH is held and serviced on entry to RUN.
        enable    = 1'b1;
        period_in = 32'd7;
        apply_tbl(0, 0, "pend");
        period_in     = 32'd99;
        period_update = 1'b1;
        tbl[4] = '{1'b1, 3'd2, 16'd99, 1'b0};
        tbl[5] = '{1'b1, 3'd3, 16'h0000, 1'b0};
        tbl[6] = '{1'b1, 3'd1, 16'h0007, 1'b0};
        tbl[7] = '{1'b0, 3'd0, 16'h0000, 1'b1};
        apply_tbl(1, 7, "pend");

        // Counter wrap 0xFFFF -> 0x0000.
        tick_ready = 1'b1;
        force dut.r_tick_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_tick_count;
        @(negedge clk);
        chk("wrap.preload", {16'd0, tick_count}, 32'h0000_FFFF);
        wait_ack(250, at);
        @(negedge clk);
        chk("wrap.tick_count", {16'd0, tick_count}, 32'd0);
        chk("wrap.tick_valid", {31'd0, tick_valid}, 32'd1);

        // Asynchronous reset in the middle of an ACK cycle.
        wait_ack(250, at);
        chk("mid_ack.cs", {31'd0, tmr_chipselect}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset("rst_mid_ack");
        @(negedge clk);
        check_reset("rst_hold");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_feed_tick_sched.md
# audio_feed_tick_sched

Sequencer that owns the audio-feed interval timer's Avalon-MM slave port. It programs the period and control registers, starts the timer in continuous interrupt mode, and services each timeout IRQ by clearing the status register. Each timeout becomes a sample-tick on a valid/ready handshake to the audio feed datapath, with a tick counter and sticky overrun detection. It sits between the feed control logic (enable/period) and the timer instance; it is the only master on that timer port.

## Interface
Parameters:
- DEFAULT_PERIOD, 32'd1133: reload value used when `period_in` is 0 (44.1 kHz at 50 MHz; the timer period is value+1 cycles).

Ports:
- clk  in  1  system clock; timer runs on the same clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high = timer should run.
- period_in  in  32  requested reload value; sampled only when programming starts.
- period_update  in  1  single-cycle pulse; reprogram the period while running.
- tick_valid  out  1  sample tick pending for the consumer.
- tick_ready  in  1  consumer accepts the tick.
- tick_count  out  16  count of timeouts serviced; wraps 0xFFFF→0.
- overrun  out  1  sticky; a timeout occurred while `tick_valid` was still pending.
- overrun_clr  in  1  pulse; clears `overrun`.
- running  out  1  high in RUN/ACK states.
- tmr_address  out  3  timer register address.
- tmr_chipselect  out  1  timer chipselect.
- tmr_write_n  out  1  timer write strobe, active-low.
- tmr_writedata  out  16  timer write data.
- tmr_irq  in  1  timer interrupt, level, held until the status register is written.

## Operation
- The timer port is write-only from this block. Every write is one cycle with `tmr_chipselect`=1 and `tmr_write_n`=0. There is no waitrequest. In all other cycles, `tmr_chipselect`=0, `tmr_write_n`=1, address=0, and data=0.
- Timer registers: 0 = status (any write clears the timeout), 1 = control, 2 = period_l, 3 = period_h.
- Control bits: [0] interrupt enable, [1] continuous, [2] start, [3] stop. The start word is 0x0007; the stop word is 0x0008.
- FSM states: IDLE, WR_PL, WR_PH, WR_CTL, RUN, ACK, STOP.
- IDLE: when `enable`=1, latch `eff_period` = (`period_in`==0 ? DEFAULT_PERIOD : `period_in`), then go to WR_PL.
- WR_PL: write address 2 with `eff_period[15:0]`, then go to WR_PH.
- WR_PH: write address 3 with `eff_period[31:16]`, then go to WR_CTL.
- WR_CTL: write address 1 with 0x0007, then go to RUN.
- RUN, in priority order:
  - `enable`=0 → STOP.
  - `period_update` → latch the new `eff_period`, then go to WR_PL. Writing the period stops the timer; the sequence restarts it.
  - `tmr_irq`=1 → ACK.
- ACK: write address 0 with 0x0000, increment `tick_count`, raise the tick, then go to RUN. The IRQ is low in the following cycle.
- STOP: write address 1 with 0x0008, then go to IDLE.
- An `enable` drop or `period_update` during WR_PL..WR_CTL does not abort the sequence. The drop is acted on in RUN, since `enable` is a level. A `period_update` pulse arriving during the sequence is captured in a pending flag and serviced on entry to RUN.
- Tick handshake:
  - `tick_valid` sets in the ACK cycle and clears when `tick_valid`&&`tick_ready`.
  - If ACK occurs while `tick_valid` is already 1 and not accepted that cycle, set `overrun`. `tick_valid` stays 1, meaning one pending tick, not a queue.
  - If ACK coincides with acceptance, `tick_valid` stays 1 and there is no overrun.
- `overrun_clr` has priority over a simultaneous set.
- `tick_count` is 16-bit modulo and is not cleared by stop; only reset clears it.

## Timing
- Reset values: state=IDLE, `tmr_chipselect`=0, `tmr_write_n`=1, `tmr_address`=0, `tmr_writedata`=0, `tick_valid`=0, `tick_count`=0, `overrun`=0, `running`=0, pending update=0.
- All outputs are registered. Timer write signals are driven in the cycle the FSM is in the corresponding write state.
- Start latency: `enable` sampled high in cycle 0 → WR_PL in cycle 1, WR_PH in cycle 2, WR_CTL in cycle 3, RUN and `running`=1 in cycle 4.
- IRQ service: `tmr_irq` sampled high in RUN at cycle N → ACK write in cycle N+1, with `tick_valid`=1 from cycle N+2. The next ACK comes no earlier than period+1 cycles later.
- Stop: `enable` low sampled in RUN at cycle N → stop write in cycle N+1, IDLE and `running`=0 in cycle N+2.
- Reset mid-operation returns to reset values immediately, with no stop write issued. The timer is reset by the same `reset_n`.

## Test plan
- Start with `period_in`=0 → writes (2,0x046D), (3,0x0000), (1,0x0007) in cycles 1–3; `running`=1 at cycle 4.
- Timer with `period_in`=99 and `tick_ready` tied to 1 → status write (0,0x0000) every 100 cycles; `tick_count` increments by 1 per IRQ; `overrun` stays 0 over 20 ticks.
- `tick_ready`=0 across two IRQs → `tick_valid` stays 1 and `overrun`=1 after the second ACK. Then `overrun_clr` → 0, and a `tick_ready` pulse → `tick_valid`=0.
- `period_update` with `period_in`=0x00010000 in RUN → writes (2,0x0000), (3,0x0001), (1,0x0007); subsequent ticks are 65537 cycles apart.
- `enable` dropped during WR_PH → sequence completes to RUN, then (1,0x0008) in the next cycle, then IDLE.
- Preload `tick_count`=0xFFFF by 65535 ticks (or force) → next ACK gives 0x0000. Asserting reset_n low mid-ACK → all outputs return to reset values asynchronously.
